cim_xbar_responder: RTL and testbench

// Crossbar-side responder of the layer<->CIM interface used by conv_layer/fc_layer: one xbar tile.

---
 rtl/cim_xbar_responder_pkg.sv | 27 ++
 rtl/cim_xbar_responder_if.sv | 30 +++
 rtl/cim_xbar_responder_weight_mem.sv | 31 +++
 rtl/cim_xbar_responder.sv | 130 +++++++++++++
 tb/tb_cim_xbar_responder.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cim_xbar_responder_pkg.sv
// Shared types and helpers for the CIM crossbar responder tile.
// Also intended for a future multi-tile wrapper.
package cim_xbar_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StAdc,
    StCommit
  } cim_state_t;

  // Accumulator width wide enough that a full-column MVM never overflows.
  function automatic int unsigned acc_width(input int unsigned dt, input int unsigned xbar);
    return 2 * dt + $clog2(xbar);
  endfunction

  // Shift then saturate to an unsigned dt-bit value; caller truncates to dt bits.
  function automatic logic [63:0] sat_quant(input logic [63:0] acc, input int unsigned shift,
                                            input int unsigned dt);
    logic [63:0] q;
    logic [63:0] sat_max;
    q       = acc >> shift;
    sat_max = (64'd1 << dt) - 64'd1;
    return (q > sat_max) ? sat_max : q;
  endfunction

endpackage

// File: rtl/cim_xbar_responder_if.sv
// Layer <-> crossbar tile bus: input-vector write, start/busy, result read, weight program.
interface cim_xbar_responder_if #(
  parameter int unsigned XbarSize     = 512,
  parameter int unsigned DatatypeSize = 2
);
  localparam int unsigned AddrW = $clog2(XbarSize);

  logic                    we;
  logic [AddrW-1:0]        wr_addr;
  logic [DatatypeSize-1:0] wr_data;
  logic                    start;
  logic                    busy;
  logic [AddrW-1:0]        rd_addr;
  logic [DatatypeSize-1:0] rd_data;
  logic                    w_we;
  logic [AddrW-1:0]        w_row;
  logic [AddrW-1:0]        w_col;
  logic [DatatypeSize-1:0] w_data;

  modport master (
    output we, wr_addr, wr_data, start, rd_addr, w_we, w_row, w_col, w_data,
    input  busy, rd_data
  );

  modport slave (
    input  we, wr_addr, wr_data, start, rd_addr, w_we, w_row, w_col, w_data,
    output busy, rd_data
  );

endinterface

// File: rtl/cim_xbar_responder_weight_mem.sv
// Crossbar weight array: single (row,col) write port, combinational full-row read port.
// Not reset: models non-volatile cells that keep their programming.
module cim_xbar_responder_weight_mem #(
  parameter int unsigned XbarSize     = 512,
  parameter int unsigned DatatypeSize = 2
) (
  input  logic                                  clk_i,
  input  logic                                  we_i,
  input  logic [$clog2(XbarSize)-1:0]           wr_row_i,
  input  logic [$clog2(XbarSize)-1:0]           wr_col_i,
  input  logic [DatatypeSize-1:0]               wr_data_i,
  input  logic [$clog2(XbarSize)-1:0]           rd_row_i,
  output logic [XbarSize-1:0][DatatypeSize-1:0] rd_data_o
);

  logic [DatatypeSize-1:0] mem_q [XbarSize][XbarSize];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < XbarSize; c++) begin
      rd_data_o[c] = mem_q[rd_row_i][c];
    end
  end

endmodule

// File: rtl/cim_xbar_responder.sv
// One crossbar tile: captures an input vector, runs a row-sequential MVM against programmed
// weights, then serves saturated column results on a registered read port.
module cim_xbar_responder
  import cim_xbar_responder_pkg::*;
#(
  parameter int unsigned XbarSize     = 512,
  parameter int unsigned DatatypeSize = 2,
  parameter int unsigned AdcCycles    = 4,
  parameter int unsigned OutShift     = 0
) (
  input logic                 clk,
  input logic                 rst,
  cim_xbar_responder_if.slave bus
);

  localparam int unsigned AddrW   = $clog2(XbarSize);
  localparam int unsigned AccW    = acc_width(DatatypeSize, XbarSize);
  localparam int unsigned AdcCntW = (AdcCycles > 1) ? $clog2(AdcCycles) : 1;
  localparam logic [AdcCntW-1:0] AdcLast = AdcCntW'((AdcCycles > 0) ? AdcCycles - 1 : 0);
  localparam logic [AddrW-1:0]   RowLast = AddrW'(XbarSize - 1);

  cim_state_t state_q, state_d;
  logic [AddrW-1:0]   row_q, row_d;
  logic [AdcCntW-1:0] adc_cnt_q, adc_cnt_d;
  logic               busy_q, busy_d;

  logic [DatatypeSize-1:0] in_q     [XbarSize];
  logic [AccW-1:0]         acc_q    [XbarSize];
  logic [AccW-1:0]         prod     [XbarSize];
  logic [DatatypeSize-1:0] result_q [XbarSize];
  logic [DatatypeSize-1:0] result_d [XbarSize];
  logic [DatatypeSize-1:0] rd_data_q;

  logic [XbarSize-1:0][DatatypeSize-1:0] w_row;

  logic idle, start_acc, in_we, w_we, acc_en, commit_en;

  cim_xbar_responder_weight_mem #(
    .XbarSize    (XbarSize),
    .DatatypeSize(DatatypeSize)
  ) u_weight_mem (
    .clk_i    (clk),
    .we_i     (w_we),
    .wr_row_i (bus.w_row),
    .wr_col_i (bus.w_col),
    .wr_data_i(bus.w_data),
    .rd_row_i (row_q),
    .rd_data_o(w_row)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      adc_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      adc_cnt_q <= adc_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StCompute;
      end
      StCompute: begin
        if (row_q == RowLast) state_d = (AdcCycles == 0) ? StCommit : StAdc;
      end
      StAdc: begin
        if (adc_cnt_q == AdcLast) state_d = StCommit;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs and counter control
  always_comb begin
    idle      = (state_q == StIdle);
    start_acc = idle && bus.start;
    in_we     = idle && bus.we;
    w_we      = idle && bus.w_we;
    acc_en    = (state_q == StCompute);
    commit_en = (state_q == StCommit);
    row_d     = acc_en ? row_q + AddrW'(1) : '0;
    adc_cnt_d = (state_q == StAdc) ? adc_cnt_q + AdcCntW'(1) : '0;
    busy_d    = (state_d != StIdle);
  end

  always_comb begin
    for (int c = 0; c < XbarSize; c++) begin
      prod[c]     = AccW'(in_q[row_q]) * AccW'(w_row[c]);
      result_d[c] = DatatypeSize'(sat_quant(64'(acc_q[c]), OutShift, DatatypeSize));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < XbarSize; i++) begin
        in_q[i]     <= '0;
        acc_q[i]    <= '0;
        result_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (in_we) in_q[bus.wr_addr] <= bus.wr_data;
      for (int c = 0; c < XbarSize; c++) begin
        if (start_acc) begin
          acc_q[c] <= '0;
        end else if (acc_en) begin
          acc_q[c] <= acc_q[c] + prod[c];
        end
        if (commit_en) result_q[c] <= result_d[c];
      end
      // Reads see result_q before this edge's commit, so a COMMIT-cycle read returns old data.
      rd_data_q <= result_q[bus.rd_addr];
    end
  end

  assign bus.busy    = busy_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_cim_xbar_responder.sv
// Randomized scoreboard bench for cim_xbar_responder with a high-level MVM reference model.
module tb_cim_xbar_responder;

  localparam int N        = 8;
  localparam int DT       = 2;
  localparam int ADC      = 2;
  localparam int BUSY_LEN = N + ADC + 1;
  localparam int OMAX     = (1 << DT) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cim_xbar_responder_if #(.XbarSize(N), .DatatypeSize(DT)) bus0 ();
  cim_xbar_responder_if #(.XbarSize(N), .DatatypeSize(DT)) bus1 ();

  assign bus1.we      = bus0.we;
  assign bus1.wr_addr = bus0.wr_addr;
  assign bus1.wr_data = bus0.wr_data;
  assign bus1.start   = bus0.start;
  assign bus1.rd_addr = bus0.rd_addr;
  assign bus1.w_we    = bus0.w_we;
  assign bus1.w_row   = bus0.w_row;
  assign bus1.w_col   = bus0.w_col;
  assign bus1.w_data  = bus0.w_data;

  cim_xbar_responder #(
    .XbarSize(N), .DatatypeSize(DT), .AdcCycles(ADC), .OutShift(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  cim_xbar_responder #(
    .XbarSize(N), .DatatypeSize(DT), .AdcCycles(ADC), .OutShift(6)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Reference model state
  int w_m [N][N];
  int in_m [N];
  int res0_m [N];
  int res1_m [N];
  int pend0 [N];
  int pend1 [N];
  int busy_left;
  int q0 [$];
  int q1 [$];
  logic rd_req;

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int quant(input int acc, input int sh);
    int q;
    q = acc >> sh;
    return (q > OMAX) ? OMAX : q;
  endfunction

  task automatic model_mvm();
    for (int c = 0; c < N; c++) begin
      int acc;
      acc = 0;
      for (int r = 0; r < N; r++) acc += in_m[r] * w_m[r][c];
      pend0[c] = quant(acc, 0);
      pend1[c] = quant(acc, 6);
    end
  endtask

  // Model the coming edge from the inputs driven now, advance one cycle, check busy.
  task automatic tick();
    if (rd_req) begin
      q0.push_back(res0_m[int'(bus0.rd_addr)]);
      q1.push_back(res1_m[int'(bus0.rd_addr)]);
    end
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        res0_m = pend0;
        res1_m = pend1;
      end
    end else begin
      if (bus0.we) in_m[int'(bus0.wr_addr)] = int'(bus0.wr_data);
      if (bus0.w_we) w_m[int'(bus0.w_row)][int'(bus0.w_col)] = int'(bus0.w_data);
      if (bus0.start) begin
        model_mvm();
        busy_left = BUSY_LEN;
      end
    end
    @(posedge clk);
    #1;
    check("busy", int'(bus0.busy), int'(busy_left > 0));
    check("busy_shift6", int'(bus1.busy), int'(busy_left > 0));
    if (bus0.busy) busy_cnt++;
    @(negedge clk);
    bus0.we      = 1'b0;
    bus0.start   = 1'b0;
    bus0.w_we    = 1'b0;
    rd_req       = 1'b1;
    bus0.rd_addr = 3'($urandom_range(0, N - 1));
  endtask

  // Read monitor: compares every issued read one edge later.
  always begin
    @(posedge clk);
    if (rd_req && rst) begin
      #1;
      if (q0.size() == 0 || q1.size() == 0) begin
        check("scoreboard_underflow", 0, 1);
      end else begin
        check("rd_data", int'(bus0.rd_data), q0.pop_front());
        check("rd_data_shift6", int'(bus1.rd_data), q1.pop_front());
      end
    end
  end

  task automatic set_w(input int r, input int c, input int d);
    bus0.w_we = 1'b1; bus0.w_row = 3'(r); bus0.w_col = 3'(c); bus0.w_data = 2'(d);
    tick();
  endtask

  task automatic set_in(input int a, input int d);
    bus0.we = 1'b1; bus0.wr_addr = 3'(a); bus0.wr_data = 2'(d);
    tick();
  endtask

  task automatic start_mvm();
    bus0.start = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_left > 0 && n < 4 * BUSY_LEN) begin
      tick();
      n++;
    end
  endtask

  task automatic read_all();
    for (int c = 0; c < N; c++) begin
      bus0.rd_addr = 3'(c);
      tick();
    end
  endtask

  task automatic do_reset();
    #2;
    rst    = 1'b0;
    rd_req = 1'b0;
    q0.delete();
    q1.delete();
    busy_left = 0;
    for (int i = 0; i < N; i++) begin
      in_m[i] = 0; res0_m[i] = 0; res1_m[i] = 0;
    end
    @(posedge clk);
    #1;
    check("rst_busy", int'(bus0.busy), 0);
    check("rst_rd_data", int'(bus0.rd_data), 0);
    check("rst_rd_data_shift6", int'(bus1.rd_data), 0);
    @(negedge clk);
    rst    = 1'b1;
    rd_req = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rd_req = 1'b0;
    bus0.we = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0; bus0.start = 1'b0;
    bus0.rd_addr = '0; bus0.w_we = 1'b0; bus0.w_row = '0; bus0.w_col = '0; bus0.w_data = '0;
    busy_left = 0;
    busy_cnt = 0;
    for (int i = 0; i < N; i++) begin
      in_m[i] = 0; res0_m[i] = 0; res1_m[i] = 0;
      for (int j = 0; j < N; j++) w_m[i][j] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("init_busy", int'(bus0.busy), 0);
    check("init_rd_data", int'(bus0.rd_data), 0);
    @(negedge clk);
    rst = 1'b1;
    rd_req = 1'b1;
    read_all();

    // Identity weights, in[r] = r % 4
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) set_w(r, c, (r == c) ? 1 : 0);
    for (int r = 0; r < N; r++) set_in(r, r % 4);
    busy_cnt = 0;
    start_mvm();
    wait_idle();
    tick();
    check("busy_len_identity", busy_cnt, BUSY_LEN);
    read_all();

    // Saturation: acc = 72 per column
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) set_w(r, c, 3);
    for (int r = 0; r < N; r++) set_in(r, 3);
    start_mvm();
    wait_idle();
    read_all();

    // Busy protection: strobes during COMPUTE must be ignored
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) set_w(r, c, $urandom_range(0, 3));
    for (int r = 0; r < N; r++) set_in(r, (r == 0) ? 1 : $urandom_range(0, 3));
    busy_cnt = 0;
    start_mvm();
    repeat (3) tick();
    bus0.we = 1'b1; bus0.wr_addr = 3'd0; bus0.wr_data = 2'd3;
    bus0.w_we = 1'b1; bus0.w_row = 3'd0; bus0.w_col = 3'd0; bus0.w_data = 2'(3 - w_m[0][0]);
    bus0.start = 1'b1;
    tick();
    wait_idle();
    tick();
    check("busy_len_protect", busy_cnt, BUSY_LEN);
    read_all();

    // Stale read: reads during MVM B return A, after COMMIT return B
    for (int r = 0; r < N; r++) set_in(r, $urandom_range(0, 3));
    start_mvm();
    for (int k = 0; k < BUSY_LEN + 2; k++) tick();
    read_all();

    // Same-cycle we + start in IDLE
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) set_w(r, c, (r == 0 && c == 0) ? 1 : 0);
    set_in(0, 0);
    bus0.we = 1'b1; bus0.wr_addr = 3'd0; bus0.wr_data = 2'd2;
    bus0.start = 1'b1;
    tick();
    wait_idle();
    repeat (2) begin
      bus0.rd_addr = 3'd0;
      tick();
    end

    // Reset mid-compute aborts; weights survive
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) set_w(r, c, $urandom_range(0, 3));
    for (int r = 0; r < N; r++) set_in(r, $urandom_range(1, 3));
    start_mvm();
    repeat (4) tick();
    do_reset();
    read_all();
    for (int r = 0; r < N; r++) set_in(r, $urandom_range(0, 3));
    start_mvm();
    wait_idle();
    read_all();

    // Random MVMs with random strobes throughout
    repeat (3) begin
      for (int k = 0; k < 20; k++) begin
        bus0.w_we = 1'($urandom_range(0, 1));
        bus0.w_row = 3'($urandom_range(0, N - 1));
        bus0.w_col = 3'($urandom_range(0, N - 1));
        bus0.w_data = 2'($urandom_range(0, 3));
        bus0.we = 1'($urandom_range(0, 1));
        bus0.wr_addr = 3'($urandom_range(0, N - 1));
        bus0.wr_data = 2'($urandom_range(0, 3));
        bus0.start = 1'($urandom_range(0, 7) == 0);
        tick();
      end
      start_mvm();
      wait_idle();
      read_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
